// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
//   db_state_t : per-channel debounce state
//   cnt_width  : width of the per-channel tick counter for a given stability length
//   db_level   : Moore decode of a state into the debounced level, per channel mode
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    // Enough bits to hold 0..stable_ticks, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned stable_ticks);
        int unsigned w;
        w = $clog2(stable_ticks + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Delayed channels report the level they are settled on, so the output only
    // moves when a wait completes. Early channels report the level they have
    // committed to, so the output moves on entry to a lockout wait.
    function automatic logic db_level(input db_state_t state, input logic early);
        if (early)
            return (state == WAIT1) || (state == ONE);
        return (state == ONE) || (state == WAIT0);
    endfunction

endpackage

// File: rtl/db_tick_gen.sv
// Shared debounce timebase.
//   clk   : system clock
//   reset : synchronous, active-high; restarts the divider at zero
//   tick  : high for one cycle every TICK_DIV cycles (every cycle when TICK_DIV == 1)
module db_tick_gen #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/multi_ch_debouncer.sv
// N-channel switch debouncer with a shared tick timebase.
// Each channel synchronises its raw input, runs its own debounce FSM in either
// delayed mode (output follows a stable input) or early mode (output follows the
// first edge, then ignores the input for a lockout period), and produces
// registered level and edge outputs.
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active-high
//   sw    : raw asynchronous switch inputs, one per channel
//   db    : debounced level per channel, registered
//   rise  : one-cycle pulse in the cycle db goes 0->1
//   fall  : one-cycle pulse in the cycle db goes 1->0
module multi_ch_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned     N_CH         = 4,
    parameter int unsigned     TICK_DIV     = 1_000_000,
    parameter int unsigned     STABLE_TICKS = 3,
    parameter logic [N_CH-1:0] EARLY_MODE   = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    localparam int unsigned      CNT_W    = cnt_width(STABLE_TICKS);
    // A wait completes on the tick that would bring cnt up to STABLE_TICKS.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic tick;

    db_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        localparam logic EARLY = EARLY_MODE[ch];

        logic             sync1;
        logic             sync2;
        db_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic             db_next;
        logic             db_q;
        logic             rise_q;
        logic             fall_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= sw[ch];
                sync2 <= sync1;
            end
        end

        assign db_next = db_level(state, EARLY);

        // db lags state by one register; rise/fall compare the level about to be
        // loaded against the current one, so they coincide with the db change.
        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= ZERO;
                cnt    <= '0;
                db_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                db_q   <= db_next;
                rise_q <= db_next & ~db_q;
                fall_q <= ~db_next & db_q;

                case (state)
                    ZERO: begin
                        if (sync2) begin
                            state <= WAIT1;
                            cnt   <= '0;
                        end
                    end

                    WAIT1: begin
                        // A reversal beats a coincident tick; early mode never reverses.
                        if (!EARLY && !sync2) begin
                            state <= ZERO;
                        end else if (tick) begin
                            if (cnt == CNT_LAST) begin
                                state <= ONE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    ONE: begin
                        if (!sync2) begin
                            state <= WAIT0;
                            cnt   <= '0;
                        end
                    end

                    WAIT0: begin
                        if (!EARLY && sync2) begin
                            state <= ONE;
                        end else if (tick) begin
                            if (cnt == CNT_LAST) begin
                                state <= ZERO;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    default: begin
                        state <= ZERO;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign db[ch]   = db_q;
        assign rise[ch] = rise_q;
        assign fall[ch] = fall_q;
    end

endmodule

// File: tb/tb_multi_ch_debouncer.sv
// Self-checking bench for multi_ch_debouncer.
// Two instances: A (TICK_DIV=4, STABLE_TICKS=3, ch1 early) and B (TICK_DIV=1,
// STABLE_TICKS=1, both delayed). A timing-level reference model predicts db,
// rise and fall every cycle from tick deadlines computed arithmetically.
module tb_multi_ch_debouncer;

    localparam int unsigned A_DIV = 4;
    localparam int unsigned A_ST  = 3;
    localparam int unsigned B_DIV = 1;
    localparam int unsigned B_ST  = 1;
    localparam logic [1:0]  A_EARLY = 2'b10;
    localparam logic [1:0]  B_EARLY = 2'b00;

    // Delayed-mode latency from the sw change to db change, in clock edges:
    // 2 sync + 1 FSM entry + wait of ((ST-1)*DIV+1 .. ST*DIV) + 1 output register.
    localparam int unsigned LAT_MIN = (A_ST - 1) * A_DIV + 5;
    localparam int unsigned LAT_MAX = A_ST * A_DIV + 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sw_a  = 2'b00;
    logic [1:0] sw_b  = 2'b00;
    logic [1:0] db_a, rise_a, fall_a;
    logic [1:0] db_b, rise_b, fall_b;

    always #5 clk = ~clk;

    multi_ch_debouncer #(
        .N_CH        (2),
        .TICK_DIV    (A_DIV),
        .STABLE_TICKS(A_ST),
        .EARLY_MODE  (A_EARLY)
    ) dut_a (
        .clk  (clk),
        .reset(reset),
        .sw   (sw_a),
        .db   (db_a),
        .rise (rise_a),
        .fall (fall_a)
    );

    multi_ch_debouncer #(
        .N_CH        (2),
        .TICK_DIV    (B_DIV),
        .STABLE_TICKS(B_ST),
        .EARLY_MODE  (B_EARLY)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .sw   (sw_b),
        .db   (db_b),
        .rise (rise_b),
        .fall (fall_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Channels 0,1 model instance A; channels 2,3 model instance B.
    bit          model_valid = 1'b0;
    int unsigned e;             // clock edges since the last reset edge
    bit          m_d1   [4];
    bit          m_d2   [4];
    bit          m_lvl  [4];    // level the channel has decided on
    bit          m_busy [4];    // a wait/lockout is in progress
    int unsigned m_dl   [4];    // edge at which the wait/lockout completes
    bit          m_db   [4];
    bit          m_rise [4];
    bit          m_fall [4];

    // Ticks land on edges where e is a multiple of div; a wait started at edge k
    // completes on the st-th tick strictly after k.
    function automatic int unsigned deadline(input int unsigned k, input int unsigned div,
                                             input int unsigned st);
        return ((k / div) + 1) * div + (st - 1) * div;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                e = 0;
                for (int c = 0; c < 4; c++) begin
                    m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_busy[c] = 0;
                    m_dl[c] = 0; m_db[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
                end
                model_valid = 1'b1;
            end else begin
                e++;
                for (int c = 0; c < 4; c++) begin
                    bit          raw, sws, old_lvl, early;
                    int unsigned div, st;
                    raw   = (c < 2) ? sw_a[c] : sw_b[c-2];
                    early = (c < 2) ? A_EARLY[c] : B_EARLY[c-2];
                    div   = (c < 2) ? A_DIV : B_DIV;
                    st    = (c < 2) ? A_ST : B_ST;
                    sws     = m_d2[c];
                    old_lvl = m_lvl[c];
                    m_d2[c] = m_d1[c];
                    m_d1[c] = raw;
                    if (early) begin
                        if (!m_busy[c]) begin
                            if (sws != m_lvl[c]) begin
                                m_lvl[c]  = sws;
                                m_busy[c] = 1;
                                m_dl[c]   = deadline(e, div, st);
                            end
                        end else if (e == m_dl[c]) begin
                            m_busy[c] = 0;
                        end
                    end else begin
                        if (!m_busy[c]) begin
                            if (sws != m_lvl[c]) begin
                                m_busy[c] = 1;
                                m_dl[c]   = deadline(e, div, st);
                            end
                        end else if (sws == m_lvl[c]) begin
                            m_busy[c] = 0;
                        end else if (e == m_dl[c]) begin
                            m_lvl[c]  = sws;
                            m_busy[c] = 0;
                        end
                    end
                    m_rise[c] = old_lvl & ~m_db[c];
                    m_fall[c] = ~old_lvl & m_db[c];
                    m_db[c]   = old_lvl;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check_eq("db_a",   db_a,   {30'd0, m_db[1],   m_db[0]});
                check_eq("rise_a", rise_a, {30'd0, m_rise[1], m_rise[0]});
                check_eq("fall_a", fall_a, {30'd0, m_fall[1], m_fall[0]});
                check_eq("db_b",   db_b,   {30'd0, m_db[3],   m_db[2]});
                check_eq("rise_b", rise_b, {30'd0, m_rise[3], m_rise[2]});
                check_eq("fall_b", fall_b, {30'd0, m_fall[3], m_fall[2]});
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int unsigned lat, rises, falls, hold_a, hold_b;
        bit          seen, changed, start_lvl;
        logic        db1_before;

        // Reset held 3 cycles with inputs high.
        sw_a  = 2'b11;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("t1_rst_db",   db_a,   0);
            check_eq("t1_rst_rise", rise_a, 0);
            check_eq("t1_rst_fall", fall_a, 0);
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("t1_post_db",   db_a,   0);
            check_eq("t1_post_rise", rise_a, 0);
        end
        sw_a = 2'b00;
        repeat (40 + $urandom_range(0, 3)) @(negedge clk);

        // Clean press on ch0.
        sw_a[0]    = 1'b1;
        db1_before = db_a[1];
        seen = 0; lat = 0; rises = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            rises += rise_a[0];
            if (db_a[0] && !seen) begin
                seen = 1;
                lat  = i;
                check_eq("t2_rise_aligned", rise_a[0], 1);
            end
            check_eq("t2_ch1_quiet", db_a[1], db1_before);
        end
        check_eq("t2_db_seen", seen, 1);
        check_eq("t2_lat_window", (lat >= LAT_MIN) && (lat <= LAT_MAX), 1);
        check_eq("t2_rise_count", rises, 1);

        // Bounce on ch0: toggle every 5 cycles, then hold high.
        sw_a[0] = 1'b0;
        repeat (20 + $urandom_range(0, 3)) @(negedge clk);
        start_lvl = db_a[0];
        check_eq("t3_start_low", start_lvl, 0);
        changed = 0;
        for (int t = 0; t < 8; t++) begin
            sw_a[0] = ~sw_a[0];
            repeat (5) begin
                @(negedge clk);
                if (db_a[0] !== start_lvl) changed = 1;
            end
        end
        check_eq("t3_no_change", changed, 0);
        sw_a[0] = 1'b1;
        seen = 0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (db_a[0] && !seen) begin
                seen = 1;
                lat  = i;
            end
        end
        check_eq("t3_settled", seen && (lat <= LAT_MAX), 1);

        // Early mode on ch1: immediate follow, lockout, release.
        sw_a[1] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                check_eq("t4_not_yet", db_a[1], 0);
            end else begin
                check_eq("t4_db_up",   db_a[1],   1);
                check_eq("t4_rise_up", rise_a[1], 1);
            end
        end
        for (int i = 0; i < 6; i++) begin
            sw_a[1] = 1'($urandom);
            @(negedge clk);
            check_eq("t4_lockout_hold", db_a[1], 1);
        end
        sw_a[1] = 1'b1;
        repeat (A_ST * A_DIV + 6) begin
            @(negedge clk);
            check_eq("t4_stays_high", db_a[1], 1);
        end
        sw_a[1] = 1'b0;
        falls = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            falls += fall_a[1];
            if (i == 4) begin
                check_eq("t4_db_down",   db_a[1],   0);
                check_eq("t4_fall_down", fall_a[1], 1);
            end
        end
        check_eq("t4_fall_count", falls, 1);

        // Reset while ch0 is waiting to release (db still high).
        sw_a[0] = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t5_pre_db", db_a[0], 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t5_db_cleared", db_a[0], 0);
        check_eq("t5_no_fall",    fall_a[0], 0);
        repeat (5) @(negedge clk);

        // Instance B (tick every cycle, one-tick stability): glitch and short pulse.
        sw_b[0] = 1'b1;
        @(negedge clk);
        sw_b[0] = 1'b0;
        changed = 0;
        repeat (10) begin
            @(negedge clk);
            if (db_b[0] !== 1'b0) changed = 1;
        end
        check_eq("t6_glitch_filtered", changed, 0);
        sw_b[0] = 1'b1;
        rises = 0; falls = 0; seen = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 3) sw_b[0] = 1'b0;
            rises += rise_b[0];
            falls += fall_b[0];
            if (db_b[0]) seen = 1;
        end
        check_eq("t6_pulse_seen", seen,  1);
        check_eq("t6_pulse_rise", rises, 1);
        check_eq("t6_pulse_fall", falls, 1);

        // Randomised hold lengths and occasional resets, checked by the model.
        hold_a = 0; hold_b = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            if (hold_a == 0) begin
                sw_a   = 2'($urandom);
                hold_a = $urandom_range(1, 30);
            end else begin
                hold_a--;
            end
            if (hold_b == 0) begin
                sw_b   = 2'($urandom);
                hold_b = $urandom_range(1, 6);
            end else begin
                hold_b--;
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
